// File: rtl/sd_emmc_cmd_tx.sv
// Serialises one SD/eMMC command frame (start, dir, index, arg, CRC7, end) onto CMD,
// advancing one bit per sd_ce strobe, then drives TAIL_BITS idle ones before releasing the line.
module sd_emmc_cmd_tx #(
  parameter int unsigned TAIL_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sd_ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam int TW = (TAIL_BITS > 0) ? $clog2(TAIL_BITS + 1) : 1;
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_BITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_TAIL  = 2'd2;

  // Handshake: a command is taken on any cycle where cmd_valid and cmd_ready are both high;
  // cmd_ready is high only in IDLE and drops the cycle after an accept.

  logic [1:0]    state_q, state_d;
  logic [39:0]   hdr_q, hdr_d;
  logic [6:0]    crc_q, crc_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;
  logic          out_q, out_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          crc_fb;

  assign crc_fb = hdr_q[39] ^ crc_q[6];

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    crc_d      = crc_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    out_d      = out_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          hdr_d     = {2'b01, cmd_index, cmd_arg};
          crc_d     = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sd_ce) begin
          oe_d      = 1'b1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q < 6'd40) begin
            out_d = hdr_q[39];
            hdr_d = {hdr_q[38:0], 1'b0};
            crc_d = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
          end else if (bit_cnt_q < 6'd47) begin
            out_d = crc_q[6];
            crc_d = {crc_q[5:0], 1'b0};
          end else begin
            out_d      = 1'b1;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
            state_d    = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (sd_ce) begin
          out_d = 1'b1;
          if (tail_cnt_q == TAIL_LAST) begin
            oe_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            tail_cnt_d = tail_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        out_d   = 1'b1;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hdr_q      <= '0;
      crc_q      <= '0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      out_q      <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      crc_q      <= crc_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_out   = out_q;
  assign cmd_oe    = oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sd_emmc_cmd_tx.sv
// Directed-plus-random bench for sd_emmc_cmd_tx: every strobe's CMD bit is checked against
// a frame built by CRC7 long division of the header.
module tb_sd_emmc_cmd_tx;

  localparam int TAIL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sd_ce;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  sd_emmc_cmd_tx #(.TAIL_BITS(TAIL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sd_ce     (sd_ce),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: header followed by remainder of header*x^7 mod (x^7+x^3+1), then end bit.
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    logic [46:0] m;
    logic [46:0] poly;
    hdr  = {2'b01, idx, arg};
    m    = {hdr, 7'b0};
    poly = 47'h89;
    for (int i = 46; i >= 7; i--)
      if (m[i]) m = m ^ (poly << (i - 7));
    return {hdr, m[6:0], 1'b1};
  endfunction

  task automatic accept_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit coinc);
    chk("ready_before_accept", cmd_ready, 1);
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    sd_ce     = coinc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sd_ce     = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_ready", cmd_ready, 0);
    chk("accept_oe", cmd_oe, 0);
    chk("accept_out", cmd_out, 1);
    chk("accept_done", done, 0);
  endtask

  // Issues strobes with random gaps in [gmin,gmax] and checks every cycle.
  task automatic run_frame(input logic [47:0] frame, input int gmin, input int gmax,
                           input bit pulse, input bit hold, input logic [5:0] nidx,
                           input logic [31:0] narg, input int abort_at);
    int   total;
    int   gap;
    logic exp_out;
    logic exp_oe;
    exp_q.delete();
    for (int i = 47; i >= 0; i--) exp_q.push_back(frame[i]);
    for (int i = 0; i < TAIL; i++) exp_q.push_back(1'b1);
    total   = 48 + TAIL + 1;
    exp_out = 1'b1;
    exp_oe  = 1'b0;
    for (int k = 1; k <= total; k++) begin
      if (abort_at > 0 && k > abort_at) return;
      gap = $urandom_range(gmax, gmin);
      for (int g = 1; g < gap; g++) begin
        sd_ce = 1'b0;
        if (pulse) begin
          cmd_valid = 1'($urandom_range(1, 0));
          cmd_index = 6'($urandom);
          cmd_arg   = $urandom;
        end
        @(posedge clk); #1;
        chk("gap_hold_out", cmd_out, exp_out);
        chk("gap_hold_oe", cmd_oe, exp_oe);
        chk("gap_done", done, 0);
      end
      cmd_valid = 1'b0;
      if (k == total && hold) begin
        cmd_valid = 1'b1;
        cmd_index = nidx;
        cmd_arg   = narg;
      end
      sd_ce = 1'b1;
      @(posedge clk); #1;
      sd_ce = 1'b0;
      if (k < total) begin
        exp_out = exp_q.pop_front();
        exp_oe  = 1'b1;
        chk($sformatf("bit%0d_out", k - 1), cmd_out, exp_out);
        chk("frame_oe", cmd_oe, 1);
        chk("frame_done", done, 0);
        chk("frame_busy", busy, 1);
        chk("frame_ready", cmd_ready, 0);
      end else begin
        exp_out = 1'b1;
        exp_oe  = 1'b0;
        chk("release_out", cmd_out, 1);
        chk("release_oe", cmd_oe, 0);
        chk("release_done", done, 1);
        chk("release_busy", busy, 0);
        chk("release_ready", cmd_ready, 1);
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      chk("done_single_pulse", done, 0);
    end
  endtask

  initial begin
    logic [5:0]  ri;
    logic [31:0] ra;
    rst_n     = 1'b0;
    sd_ce     = 1'b0;
    cmd_valid = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_out", cmd_out, 1);
    chk("rst_oe", cmd_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CMD0, strobe every 4 clk
    accept_cmd(6'd0, 32'h0, 1'b0);
    run_frame(48'h40_00000000_95, 4, 4, 1'b0, 1'b0, '0, '0, 0);

    // CMD8 with sd_ce coincident with accept
    accept_cmd(6'd8, 32'h0000_01AA, 1'b1);
    run_frame(48'h48_000001AA_87, 4, 4, 1'b0, 1'b0, '0, '0, 0);

    // CMD17 then CMD55 with cmd_valid held through release
    accept_cmd(6'd17, 32'h0, 1'b0);
    run_frame(48'h51_00000000_55, 1, 3, 1'b0, 1'b1, 6'd55, 32'h0, 0);
    accept_cmd(6'd55, 32'h0, 1'b0);
    run_frame(48'h77_00000000_65, 1, 3, 1'b0, 1'b0, '0, '0, 0);

    // CMD8 with irregular gaps
    accept_cmd(6'd8, 32'h0000_01AA, 1'b0);
    run_frame(48'h48_000001AA_87, 1, 20, 1'b0, 1'b0, '0, '0, 0);

    // Reset mid-frame after bit 20 has been driven
    accept_cmd(6'd0, 32'h0, 1'b0);
    run_frame(48'h40_00000000_95, 2, 4, 1'b0, 1'b0, '0, '0, 21);
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", cmd_oe, 0);
    chk("midrst_out", cmd_out, 1);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("postrst_done", done, 0);
      chk("postrst_oe", cmd_oe, 0);
    end
    accept_cmd(6'd0, 32'h0, 1'b0);
    run_frame(48'h40_00000000_95, 1, 4, 1'b0, 1'b0, '0, '0, 0);

    // Random commands, cmd_valid noise during frame, against the model
    for (int n = 0; n < 6; n++) begin
      ri = 6'($urandom);
      ra = $urandom;
      accept_cmd(ri, ra, 1'($urandom_range(1, 0)));
      run_frame(model_frame(ri, ra), 1, 6, 1'b1, 1'b0, '0, '0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Time bound so a stalled run still ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
